// File: rtl/cpu_pkg.sv
// Shared CPU definitions: legal opcode set, fetch FSM states and opcode field geometry.
// Used by instr_fetch and by the downstream control_unit decoder.
package cpu_pkg;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 16;
  localparam int OPC_W       = 4;
  localparam int OPC_MSB     = DEF_INSTR_W - 1;
  localparam int OPC_LSB     = DEF_INSTR_W - OPC_W;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_JMP   = 4'h7
  } opcode_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

  // Every legal opcode has the top bit clear.
  function automatic logic opc_legal(input logic [OPC_W-1:0] op);
    return ~op[OPC_W-1];
  endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// Two-entry FIFO of {instruction, pc} between instruction memory and decode.
// Flush takes priority over push and pop in the same cycle.
module fetch_buffer #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [PC_W-1:0]    push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [INSTR_W-1:0] head_instr,
  output logic [PC_W-1:0]    head_pc,
  output logic [1:0]         count
);

  logic [INSTR_W-1:0] instr_q [2];
  logic [PC_W-1:0]    pc_q    [2];
  logic               rd_ptr_q;
  logic               wr_ptr_q;
  logic [1:0]         count_q;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        instr_q[wr_ptr_q] <= push_instr;
        pc_q[wr_ptr_q]    <= push_pc;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_instr = instr_q[rd_ptr_q];
  assign head_pc    = pc_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, read issue to a 1-cycle synchronous imem, 2-entry buffer,
// valid/ready delivery to decode, redirect flush and sticky halt on illegal opcodes.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
);

  // state   | meaning
  // FS_IDLE | not fetching; waits for enable
  // FS_RUN  | issuing reads while enable is high and the buffer has room
  // FS_HALT | illegal opcode seen; no issue, redirect/enable ignored until reset

  localparam int OPC_POS = INSTR_W - OPC_W;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    inflight_pc_q;
  logic               inflight_q;
  logic [1:0]         buf_count;
  logic [INSTR_W-1:0] buf_instr;
  logic [PC_W-1:0]    buf_pc;
  logic               halt_st;
  logic               redirect_ok;
  logic               rsp_ok;
  logic               rsp_illegal;
  logic               buf_empty;
  logic               pop;
  logic               issue;
  logic               buf_push;
  logic [2:0]         occupancy;

  assign halt_st     = (state_q == FS_HALT);
  assign redirect_ok = redirect && !halt_st;
  assign buf_empty   = (buf_count == 2'd0);

  // A response arriving in HALT belongs to a read issued alongside the illegal capture.
  assign rsp_ok      = inflight_q && !halt_st && opc_legal(imem_rdata[INSTR_W-1:OPC_POS]);
  assign rsp_illegal = inflight_q && !halt_st && !redirect_ok
                       && !opc_legal(imem_rdata[INSTR_W-1:OPC_POS]);

  // An empty buffer presents the arriving word directly so delivery needs no extra cycle.
  assign instr_valid = !buf_empty || rsp_ok;
  assign instr       = !buf_empty ? buf_instr : (rsp_ok ? imem_rdata : '0);
  assign instr_pc    = !buf_empty ? buf_pc : (rsp_ok ? inflight_pc_q : '0);
  assign opcode      = instr[INSTR_W-1:OPC_POS];
  assign pop         = instr_valid && instr_ready;

  assign buf_push  = rsp_ok && !redirect_ok && !(buf_empty && pop);
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == FS_RUN) && enable && !redirect && (occupancy < 3'd2);
  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign halted    = halt_st;

  fetch_buffer #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (buf_push),
    .push_instr (imem_rdata),
    .push_pc    (inflight_pc_q),
    .pop        (pop),
    .flush      (redirect_ok),
    .head_instr (buf_instr),
    .head_pc    (buf_pc),
    .count      (buf_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FS_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
      if (redirect_ok) begin
        pc_q <= redirect_pc;
      end else if (issue) begin
        pc_q <= pc_q + PC_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE: if (enable) state_d = FS_RUN;
      FS_RUN:  if (!enable && !inflight_q) state_d = FS_IDLE;
      FS_HALT: state_d = FS_HALT;
      default: state_d = FS_IDLE;
    endcase
    if (rsp_illegal) begin
      state_d = FS_HALT;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// ready/redirect run scored against an in-order program-stream model.
module tb_instr_fetch;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               halted;

  logic [INSTR_W-1:0] mem [256];
  int checks = 0;
  int passes = 0;

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #2;
    checks++; if (imem_en !== 1'b0) $display("FAIL reset_imem_en: got %b want 0", imem_en); else passes++;
    checks++; if (imem_addr !== 8'h00) $display("FAIL reset_imem_addr: got %h want 00", imem_addr); else passes++;
    checks++; if (instr !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", instr); else passes++;
    checks++; if (opcode !== 4'h0) $display("FAIL reset_opcode: got %h want 0", opcode); else passes++;
    checks++; if (instr_pc !== 8'h00) $display("FAIL reset_instr_pc: got %h want 00", instr_pc); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passes++;
  endtask

  task automatic test_stream();
    logic [PC_W-1:0] e;
    for (int k = 0; k < 256; k++) mem[k] = {1'b0, 3'(k % 8), 12'($urandom)};
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    tick(); @(negedge clk);
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL stream_first_issue: got en=%b addr=%h want en=1 addr=00", imem_en, imem_addr); else passes++;
    for (int i = 0; i < 260; i++) begin
      tick(); @(negedge clk);
      e = 8'(i);
      checks++; if (instr_valid !== 1'b1) $display("FAIL stream_valid: cycle %0d got %b want 1", i, instr_valid); else passes++;
      checks++; if (instr_pc !== e) $display("FAIL stream_pc: got %h want %h", instr_pc, e); else passes++;
      checks++; if (instr !== mem[e]) $display("FAIL stream_instr: got %h want %h", instr, mem[e]); else passes++;
      checks++; if (opcode !== 4'(i % 8)) $display("FAIL stream_opcode: got %h want %h", opcode, 4'(i % 8)); else passes++;
      checks++; if (imem_en !== 1'b1 || imem_addr !== 8'(i + 1))
        $display("FAIL stream_issue: got en=%b addr=%h want en=1 addr=%h", imem_en, imem_addr, 8'(i + 1)); else passes++;
    end
  endtask

  task automatic test_stall();
    logic [INSTR_W-1:0] held;
    logic [PC_W-1:0]    held_pc;
    logic [PC_W-1:0]    e;
    int                 issues;
    tick(); instr_ready = 1'b0; @(negedge clk);
    held = instr; held_pc = instr_pc; issues = int'(imem_en);
    checks++; if (instr_valid !== 1'b1 || held_pc !== 8'h04)
      $display("FAIL stall_head: got valid=%b pc=%h want valid=1 pc=04", instr_valid, held_pc); else passes++;
    for (int s = 1; s < 5; s++) begin
      tick(); @(negedge clk);
      issues += int'(imem_en);
      checks++; if (instr_valid !== 1'b1 || instr !== held || opcode !== held[15:12] || instr_pc !== held_pc)
        $display("FAIL stall_hold: got v=%b %h/%h/%h want v=1 %h/%h/%h", instr_valid, instr, opcode, instr_pc,
                 held, held[15:12], held_pc); else passes++;
    end
    checks++; if (issues !== 1) $display("FAIL stall_issue_count: got %0d want 1", issues); else passes++;
    tick(); instr_ready = 1'b1; @(negedge clk);
    checks++; if (imem_en !== 1'b1) $display("FAIL stall_resume_issue: got %b want 1", imem_en); else passes++;
    checks++; if (instr_pc !== held_pc || instr !== held)
      $display("FAIL stall_resume_head: got %h/%h want %h/%h", instr_pc, instr, held_pc, held); else passes++;
    for (int j = 1; j <= 8; j++) begin
      tick(); @(negedge clk);
      e = held_pc + 8'(j);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== e || instr !== mem[e])
        $display("FAIL stall_after: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 instr_valid, instr_pc, instr, e, mem[e]); else passes++;
    end
  endtask

  task automatic test_redirect();
    logic [PC_W-1:0] e;
    tick(); instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h40; @(negedge clk);
    checks++; if (imem_en !== 1'b0) $display("FAIL redir_no_issue: got %b want 0", imem_en); else passes++;
    tick(); redirect = 1'b0; instr_ready = 1'b1; @(negedge clk);
    checks++; if (instr_valid !== 1'b0) $display("FAIL redir_flush_valid: got %b want 0", instr_valid); else passes++;
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h40)
      $display("FAIL redir_addr: got en=%b addr=%h want en=1 addr=40", imem_en, imem_addr); else passes++;
    for (int j = 0; j < 7; j++) begin
      tick(); @(negedge clk);
      e = 8'h40 + 8'(j);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== e || instr !== mem[e])
        $display("FAIL redir_stream: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 instr_valid, instr_pc, instr, e, mem[e]); else passes++;
    end
  endtask

  task automatic test_halt();
    logic [INSTR_W-1:0] saved;
    saved = mem[3];
    mem[3] = 16'h9abc;
    do_reset();
    enable = 1'b1; @(negedge clk);
    tick(); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'(i))
        $display("FAIL halt_prefix: got v=%b pc=%h want v=1 pc=%h", instr_valid, instr_pc, 8'(i)); else passes++;
    end
    tick(); @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL halt_capture_cycle: got v=%b halted=%b want v=0 halted=0", instr_valid, halted); else passes++;
    tick(); @(negedge clk);
    checks++; if (halted !== 1'b1 || imem_en !== 1'b0)
      $display("FAIL halt_entry: got halted=%b en=%b want halted=1 en=0", halted, imem_en); else passes++;
    tick(); redirect = 1'b1; redirect_pc = 8'h10; @(negedge clk);
    checks++; if (halted !== 1'b1 || imem_en !== 1'b0)
      $display("FAIL halt_redirect_ignored: got halted=%b en=%b want 1/0", halted, imem_en); else passes++;
    tick(); redirect = 1'b0; @(negedge clk);
    checks++; if (halted !== 1'b1 || imem_en !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL halt_sticky: got halted=%b en=%b v=%b want 1/0/0", halted, imem_en, instr_valid); else passes++;
    mem[3] = saved;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; @(negedge clk);
    for (int i = 0; i < 4; i++) begin tick(); @(negedge clk); end
    tick(); instr_ready = 1'b0; #2;
    checks++; if (instr_valid !== 1'b1 || imem_en !== 1'b1)
      $display("FAIL rstmid_pre: got v=%b en=%b want 1/1", instr_valid, imem_en); else passes++;
    reset = 1'b1; #1;
    checks++; if (imem_en !== 1'b0 || imem_addr !== 8'h00 || instr !== 16'h0000 || opcode !== 4'h0 ||
                  instr_pc !== 8'h00 || instr_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL rstmid_async: got en=%b addr=%h instr=%h op=%h pc=%h v=%b h=%b want all zero",
               imem_en, imem_addr, instr, opcode, instr_pc, instr_valid, halted); else passes++;
    @(negedge clk); tick(); tick();
    reset = 1'b0; instr_ready = 1'b1; @(negedge clk);
    tick(); @(negedge clk);
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL rstmid_refetch: got en=%b addr=%h want 1/00", imem_en, imem_addr); else passes++;
    tick(); @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== mem[0])
      $display("FAIL rstmid_first: got v=%b pc=%h instr=%h want 1/00/%h", instr_valid, instr_pc, instr, mem[0]); else passes++;
  endtask

  task automatic test_illegal_redirect();
    logic [INSTR_W-1:0] saved;
    saved = mem[2];
    mem[2] = 16'hf123;
    do_reset();
    enable = 1'b1; @(negedge clk);
    tick(); @(negedge clk);
    tick(); @(negedge clk);
    tick(); @(negedge clk);
    tick(); redirect = 1'b1; redirect_pc = 8'h20; @(negedge clk);
    checks++; if (instr_valid !== 1'b0) $display("FAIL illredir_drop: got v=%b want 0", instr_valid); else passes++;
    tick(); redirect = 1'b0; @(negedge clk);
    checks++; if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 8'h20)
      $display("FAIL illredir_restart: got h=%b en=%b addr=%h want 0/1/20", halted, imem_en, imem_addr); else passes++;
    tick(); @(negedge clk);
    checks++; if (halted !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h20 || instr !== mem[8'h20])
      $display("FAIL illredir_deliver: got h=%b v=%b pc=%h want 0/1/20", halted, instr_valid, instr_pc); else passes++;
    mem[2] = saved;
  endtask

  task automatic test_random();
    logic [PC_W-1:0]    exp_pc;
    logic [INSTR_W-1:0] prev_instr;
    logic [PC_W-1:0]    prev_pc;
    logic               prev_hold;
    logic               seen;
    int                 delivered;
    for (int k = 0; k < 256; k++) mem[k] = {1'b0, 15'($urandom)};
    do_reset();
    enable = 1'b1; @(negedge clk);
    exp_pc = '0; prev_hold = 1'b0; delivered = 0;
    prev_instr = '0; prev_pc = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      instr_ready = ($urandom % 4) != 0;
      redirect    = ($urandom % 16) == 0;
      redirect_pc = 8'($urandom);
      @(negedge clk);
      if (prev_hold) begin
        checks++; if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc)
          $display("FAIL rand_hold: got v=%b %h@%h want v=1 %h@%h", instr_valid, instr, instr_pc, prev_instr, prev_pc); else passes++;
      end
      if (instr_valid) begin
        checks++; if (instr_pc !== exp_pc || instr !== mem[exp_pc])
          $display("FAIL rand_order: got %h@%h want %h@%h", instr, instr_pc, mem[exp_pc], exp_pc); else passes++;
      end
      if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 8'd1;
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
      prev_hold  = instr_valid && !instr_ready && !redirect;
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
    tick(); instr_ready = 1'b1; redirect = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (instr_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++; if (seen !== 1'b1) $display("FAIL rand_liveness: got no valid within 6 cycles want valid"); else passes++;
    checks++; if (instr_pc !== exp_pc) $display("FAIL rand_final_pc: got %h want %h", instr_pc, exp_pc); else passes++;
    checks++; if (delivered < 100) $display("FAIL rand_throughput: got %0d want >=100", delivered); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL rand_halted: got %b want 0", halted); else passes++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_illegal_redirect();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit and producer of the 4-bit opcode stream that `control_unit` decodes. It holds the PC and issues reads to a synchronous instruction memory with one-cycle read latency. Fetched words pass through a 2-entry buffer and go to decode over a valid/ready handshake. Decode and branch resolution can redirect the PC, and the unit halts on any opcode outside the legal 4'h0–4'h7 set.

## Interface
- `PC_W`, 8, fetch address width; PC wraps modulo 2^PC_W
- `INSTR_W`, 16, instruction width; opcode field is `[INSTR_W-1:INSTR_W-4]`
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: level; fetching is allowed while high.
- `imem_en` out 1: read strobe.
- `imem_addr` out PC_W: read address, valid when `imem_en`=1.
- `imem_rdata` in INSTR_W: read data, valid the cycle after `imem_en`.
- `instr` out INSTR_W: head-of-buffer instruction.
- `opcode` out 4: `instr[INSTR_W-1:INSTR_W-4]`, feeds `control_unit`.
- `instr_pc` out PC_W: address `instr` was fetched from.
- `instr_valid` out 1: `instr` is presentable.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `redirect` in 1: flush and restart at `redirect_pc`.
- `redirect_pc` in PC_W: new fetch address.
- `halted` out 1: illegal opcode seen, sticky until reset.

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE with PC=0, buffer empty, no read in flight.
- IDLE→RUN when `enable`=1. RUN→IDLE when `enable`=0 and no read is in flight. Any state→HALT on an illegal capture.
- Issue rule (RUN only): `imem_en`=1 iff `enable` && !`redirect` && (buffered + in-flight − pop) < 2.
  - pop = `instr_valid` && `instr_ready`.
  - `imem_addr`=PC. PC ← PC+1 (wraps 2^PC_W−1→0) on each issue.
- Capture: the cycle after an issue, `imem_rdata` is written to the buffer tail with its PC, unless it has been dropped.
- Buffer: 2-entry FIFO; its head drives `instr`/`instr_pc`/`instr_valid`.
  - Pop and capture in the same cycle are both honoured.
  - The issue rule prevents overflow; capture into a full buffer is unreachable.
- Handshake: while `instr_valid`=1 and `instr_ready`=0, `instr`, `opcode` and `instr_pc` stay stable. Valid never drops without a pop, redirect, or reset.
- Redirect (RUN or IDLE):
  - Buffer is cleared and any in-flight response is dropped.
  - PC ← `redirect_pc`; no issue that cycle.
  - An instruction popped in the same cycle counts as delivered.
- Illegal opcode: a captured word with opcode bit 3 = 1 is not buffered.
  - State → HALT, `halted`=1 next cycle.
  - Issue stops; legal entries already buffered still drain.
- HALT: `imem_en`=0, `redirect` and `enable` are ignored; only `reset` exits.
- Redirect coinciding with an illegal response: redirect wins, the response is dropped, and there is no halt.

## Timing
- Reset values: `imem_en`=0, `imem_addr`=0, `instr`=0, `opcode`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0.
- Async reset clears all state immediately, mid-operation included; in-flight data is discarded.
- `enable` high at edge c in IDLE:
  - RUN at c+1; `imem_en`=1 with `imem_addr`=0 in cycle c+1.
  - `instr_valid`=1 with mem[0] in cycle c+2.
- Steady state with `instr_ready`=1: one instruction per cycle, PCs consecutive.
- `instr_ready` low: at most 2 more words land in the buffer (one in flight, one buffered), then issue stops. With ready back high, issue resumes the same cycle and there are no gaps.
- Redirect sampled at cycle t:
  - `instr_valid`=0 at t+1.
  - `imem_addr`=`redirect_pc` at t+1.
  - `instr_valid`=1 with that instruction at t+2.
- Illegal capture at cycle t: `halted`=1 and `imem_en`=0 from t+1.

## Structure
- `cpu_pkg` holds:
  - `opcode_t` (legal 4'h0–4'h7) and `fetch_state_t`;
  - `PC_W`/`INSTR_W` defaults;
  - opcode field position localparams, shared with `control_unit`.
- Sub-module `fetch_buffer`: 2-entry FIFO of {instr, pc} with push/pop/flush/count. The top level holds the FSM, PC, in-flight/drop flags and issue logic.

## Test plan
- Reset, `enable`=1, `instr_ready`=1, memory word k has opcode k%8, PC_W=8 → addresses 0,1,2… issued back to back; `instr_pc` 0,1,2… one per cycle starting 2 cycles after enable; address wraps 255→0.
- `instr_ready` low for 5 cycles mid-stream → `instr` and `opcode` held; exactly 2 words buffered; no instruction lost or duplicated after ready returns.
- `redirect`=1, `redirect_pc`=8'h40 at cycle t with the buffer full and a read in flight → `instr_valid`=0 at t+1, `imem_addr`=8'h40 at t+1, `instr_pc`=8'h40 at t+2; flushed instructions never appear.
- mem[3] opcode 4'h9 → instructions 0–2 delivered, `halted`=1, `imem_en` stays 0; a later `redirect` is ignored.
- Assert `reset` while `instr_valid`=1 and a read is in flight → all outputs at reset values immediately; refetch from PC 0 after release.
- Illegal response and `redirect` in the same cycle → no halt; fetch resumes at `redirect_pc`.
